// File: rtl/sd_audio_stream_ctrl_pkg.sv
// Shared definitions for the SD-card audio streaming controller:
// FSM state encoding, SD block size and address helpers.
package sd_audio_stream_ctrl_pkg;

   localparam int SD_BLOCK_BYTES = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ISSUE,
      ST_RECV,
      ST_NEXT,
      ST_DRAIN,
      ST_FLUSH
   } state_t;

   // Round a byte address down to the start of its SD block.
   function automatic logic [31:0] block_align(input logic [31:0] adr, input int bytes);
      return adr & ~32'(bytes - 1);
   endfunction

endpackage

// File: rtl/sd_audio_stream_ctrl_rise_detect.sv
// Two-flop rising-edge detector; evt is high for one cycle per low-to-high
// transition of d, so a level held high produces a single event.
module rise_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic evt
);

   logic cur;
   logic last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur  <= 1'b0;
         last <= 1'b0;
      end else begin
         cur  <= d;
         last <= cur;
      end
   end

   assign evt = cur & ~last;

endmodule

// File: rtl/sd_audio_stream_ctrl.sv
// Streams a clip [start_adr, stop_adr) from the SD card into the sample FIFO
// one block at a time, and paces FIFO reads at the sample tick rate.
module sd_audio_stream_ctrl
   import sd_audio_stream_ctrl_pkg::*;
#(
   parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
   parameter int FIFO_DEPTH  = 8192,
   parameter int COUNT_W     = 14,
   parameter int UNDER_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        start_adr,
   input  logic [31:0]        stop_adr,
   input  logic               sample_clk,
   input  logic               sd_ready,
   input  logic               sd_byte_avail,
   output logic               sd_rd,
   output logic [31:0]        sd_adr,
   input  logic [COUNT_W-1:0] fifo_count,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   output logic               fifo_wr_en,
   output logic               fifo_rd_en,
   output logic               playing,
   output logic               pwm_en,
   output logic               done,
   output logic               overflow,
   output logic [UNDER_W-1:0] underrun_count
);

   localparam int BC_W = $clog2(BLOCK_BYTES + 1);
   localparam logic [COUNT_W-1:0] ROOM_MAX = COUNT_W'(FIFO_DEPTH - BLOCK_BYTES);

   state_t          state;
   logic [31:0]     stop_r;
   logic [BC_W-1:0] byte_cnt;
   logic            byte_evt;
   logic            tick_evt;
   logic [31:0]     start_blk;
   logic [31:0]     adr_next;
   logic            byte_last;
   logic            room;
   logic            pacing;

   rise_detect u_byte_rise (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sd_byte_avail),
      .evt     (byte_evt)
   );

   rise_detect u_tick_rise (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (sample_clk),
      .evt     (tick_evt)
   );

   assign start_blk = block_align(start_adr, BLOCK_BYTES);
   assign adr_next  = sd_adr + 32'(BLOCK_BYTES);
   assign byte_last = (byte_cnt == BC_W'(BLOCK_BYTES - 1));
   assign room      = (fifo_count <= ROOM_MAX);
   assign pacing    = (state != ST_IDLE) && (state != ST_FLUSH);
   assign pwm_en    = playing;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         sd_rd      <= 1'b0;
         sd_adr     <= '0;
         stop_r     <= '0;
         byte_cnt   <= '0;
         fifo_wr_en <= 1'b0;
         done       <= 1'b0;
         playing    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  sd_adr   <= start_blk;
                  stop_r   <= stop_adr;
                  byte_cnt <= '0;
                  if (stop_adr <= start_blk) begin
                     done <= 1'b1;
                  end else begin
                     playing  <= 1'b1;
                     overflow <= 1'b0;
                     state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (abort) begin
                  playing <= 1'b0;
                  state   <= ST_IDLE;
               end else if (sd_ready && room) begin
                  sd_rd <= 1'b1;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!sd_ready) sd_rd <= 1'b0;
               if (abort)          state <= ST_FLUSH;
               else if (!sd_ready) state <= ST_RECV;
            end
            ST_RECV: begin
               if (byte_evt) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (!abort) begin
                     if (fifo_full) overflow   <= 1'b1;
                     else           fifo_wr_en <= 1'b1;
                  end
               end
               // An abort landing on the final byte has nothing left to flush.
               if (byte_evt && byte_last) begin
                  if (abort) begin
                     byte_cnt <= '0;
                     playing  <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     state <= ST_NEXT;
                  end
               end else if (abort) begin
                  state <= ST_FLUSH;
               end
            end
            ST_NEXT: begin
               byte_cnt <= '0;
               sd_adr   <= adr_next;
               if (abort) begin
                  playing <= 1'b0;
                  state   <= ST_IDLE;
               end else if (adr_next >= stop_r) begin
                  state <= ST_DRAIN;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  playing <= 1'b0;
                  state   <= ST_IDLE;
               end else if (fifo_empty) begin
                  done    <= 1'b1;
                  playing <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // A read aborted before its acknowledge is still outstanding.
               if (sd_rd && !sd_ready) sd_rd <= 1'b0;
               if (byte_evt) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_last) begin
                     byte_cnt <= '0;
                     playing  <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sample pacing: one FIFO read per tick; ticks that find the FIFO empty
   // while still loading are counted as underruns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_rd_en     <= 1'b0;
         underrun_count <= '0;
      end else begin
         fifo_rd_en <= 1'b0;
         if (pacing && tick_evt) begin
            if (!fifo_empty) begin
               fifo_rd_en <= 1'b1;
            end else if (state != ST_DRAIN && underrun_count != '1) begin
               underrun_count <= underrun_count + 1'b1;
            end
         end
      end
   end

endmodule
